qsys_block_nios2e_oci_dct_packer: RTL and testbench



---
 rtl/qsys_block_nios2e_oci_dct_packer_pkg.sv | 23 ++
 rtl/qsys_block_nios2e_oci_dct_packer_if.sv | 41 ++++
 rtl/qsys_block_nios2e_oci_dct_packer_frame_reg.sv | 98 +++++++++
 rtl/qsys_block_nios2e_oci_dct_packer.sv | 81 ++++++++
 tb/tb_qsys_block_nios2e_oci_dct_packer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/qsys_block_nios2e_oci_dct_packer_pkg.sv
// rtl/qsys_block_nios2e_oci_dct_packer_pkg.sv - shared constants and types for the DCT packer
// Purpose: frame geometry, branch-code encodings and buffer/count types.
// Ports: none (package).
package qsys_block_nios2e_oci_dct_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_DEPTH  = 15;
  localparam int DCT_BUF_W  = DCT_CODE_W * DCT_DEPTH;
  localparam int DCT_CNT_W  = 4;
  localparam int DROP_CNT_W = 8;

  localparam logic [DCT_CODE_W-1:0] DCT_NT   = 2'b01;
  localparam logic [DCT_CODE_W-1:0] DCT_TK   = 2'b10;
  localparam logic [DCT_CODE_W-1:0] DCT_MARK = 2'b11;
  localparam logic [DCT_CODE_W-1:0] DCT_ILL  = 2'b00;

  localparam logic [DCT_CNT_W-1:0] DCT_LAST_CNT = 4'(DCT_DEPTH - 1);

  typedef logic [DCT_BUF_W-1:0]  dct_buf_t;
  typedef logic [DCT_CNT_W-1:0]  dct_cnt_t;
  typedef logic [DCT_CODE_W-1:0] dct_code_t;

endpackage

// File: rtl/qsys_block_nios2e_oci_dct_packer_if.sv
// rtl/qsys_block_nios2e_oci_dct_packer_if.sv - branch-code input, frame output and status bundle
// Purpose: groups the packer's non-clock signals.
// Modports: master drives branch codes / frame_ready / overflow_clr and observes the rest;
//           slave is the packer itself.
// Optional: QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN adds drop_cnt.
interface qsys_block_nios2e_oci_dct_packer_if;
  import qsys_block_nios2e_oci_dct_pkg::*;

  logic      trc_on;
  logic      dct_valid;
  dct_code_t dct_code;
  logic      flush_req;
  logic      frame_ready;
  logic      frame_valid;
  dct_buf_t  frame_buf;
  dct_cnt_t  frame_cnt;
  dct_buf_t  dct_buffer;
  dct_cnt_t  dct_count;
  logic      overflow;
  logic      overflow_clr;
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  modport master (
    output trc_on, dct_valid, dct_code, flush_req, frame_ready, overflow_clr,
    input  frame_valid, frame_buf, frame_cnt, dct_buffer, dct_count, overflow
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  trc_on, dct_valid, dct_code, flush_req, frame_ready, overflow_clr,
    output frame_valid, frame_buf, frame_cnt, dct_buffer, dct_count, overflow
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/qsys_block_nios2e_oci_dct_packer_frame_reg.sv
// rtl/qsys_block_nios2e_oci_dct_packer_frame_reg.sv - valid/ready frame holding register
// Purpose: takes an offered frame when empty or being drained, otherwise drops it
//          and raises the sticky overflow flag.
// Ports: clk, reset_n; offer_i/offer_buf_i/offer_cnt_i (new frame); frame_ready_i;
//        overflow_clr_i; frame_valid_o/frame_buf_o/frame_cnt_o; overflow_o;
//        drop_cnt_o when QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN is defined.
module qsys_block_nios2e_oci_dct_frame_reg
  import qsys_block_nios2e_oci_dct_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     offer_i,
  input  dct_buf_t offer_buf_i,
  input  dct_cnt_t offer_cnt_i,
  input  logic     frame_ready_i,
  input  logic     overflow_clr_i,
  output logic     frame_valid_o,
  output dct_buf_t frame_buf_o,
  output dct_cnt_t frame_cnt_o,
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
`endif
  output logic     overflow_o
);

  logic     valid_q, valid_d;
  dct_buf_t buf_q, buf_d;
  dct_cnt_t cnt_q, cnt_d;
  logic     ovf_q, ovf_d;
  logic     load, drop;

  // The slot is free if empty or if its current frame leaves on this edge.
  assign load = offer_i && (!valid_q || frame_ready_i);
  assign drop = offer_i && valid_q && !frame_ready_i;

  always_comb begin
    valid_d = valid_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (load) begin
      valid_d = 1'b1;
      buf_d   = offer_buf_i;
      cnt_d   = offer_cnt_i;
    end else if (valid_q && frame_ready_i) begin
      valid_d = 1'b0;
    end
    // Clear wins over a same-cycle drop.
    if (overflow_clr_i) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign frame_valid_o = valid_q;
  assign frame_buf_o   = buf_q;
  assign frame_cnt_o   = cnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/qsys_block_nios2e_oci_dct_packer.sv
// rtl/qsys_block_nios2e_oci_dct_packer.sv - packs DCT branch codes into 15-entry trace frames
// Purpose: shift buffer, entry counter and frame-close logic; frames go to the holding register.
// Ports: clk, reset_n (async, active-low); bus (slave modport) carrying trc_on, dct_valid,
//        dct_code, flush_req, frame_ready, overflow_clr in and frame_valid, frame_buf,
//        frame_cnt, dct_buffer, dct_count, overflow out.
// Optional: QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN adds the saturating drop_cnt output.
module qsys_block_nios2e_oci_dct_packer
  import qsys_block_nios2e_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  qsys_block_nios2e_oci_dct_packer_if.slave bus
);

  dct_buf_t buf_q, buf_d;
  dct_cnt_t cnt_q, cnt_d;
  logic     trc_q;

  logic     accept;
  logic     trc_fall;
  logic     close;
  dct_buf_t eff_buf;
  dct_cnt_t eff_cnt;

  assign accept   = bus.dct_valid && bus.trc_on && (bus.dct_code != DCT_ILL);
  assign trc_fall = trc_q && !bus.trc_on;

  // The frame being closed includes a code accepted on the same edge.
  assign eff_buf = accept ? {buf_q[DCT_BUF_W-DCT_CODE_W-1:0], bus.dct_code} : buf_q;
  assign eff_cnt = accept ? cnt_q + 1'b1 : cnt_q;

  // trc_on is low during a falling edge, so no accept can coincide with it.
  assign close = (accept && (cnt_q == DCT_LAST_CNT))
              || (bus.flush_req && (eff_cnt != '0))
              || (trc_fall && (cnt_q != '0));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (close) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      buf_d = eff_buf;
      cnt_d = eff_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      trc_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      trc_q <= bus.trc_on;
    end
  end

  qsys_block_nios2e_oci_dct_frame_reg u_frame_reg (
    .clk            (clk),
    .reset_n        (reset_n),
    .offer_i        (close),
    .offer_buf_i    (eff_buf),
    .offer_cnt_i    (eff_cnt),
    .frame_ready_i  (bus.frame_ready),
    .overflow_clr_i (bus.overflow_clr),
    .frame_valid_o  (bus.frame_valid),
    .frame_buf_o    (bus.frame_buf),
    .frame_cnt_o    (bus.frame_cnt),
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
    .drop_cnt_o     (bus.drop_cnt),
`endif
    .overflow_o     (bus.overflow)
  );

  assign bus.dct_buffer = buf_q;
  assign bus.dct_count  = cnt_q;

endmodule

// File: tb/tb_qsys_block_nios2e_oci_dct_packer.sv
// tb/tb_qsys_block_nios2e_oci_dct_packer.sv - scoreboard bench for the DCT packer
module tb_qsys_block_nios2e_oci_dct_packer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  qsys_block_nios2e_oci_dct_packer_if bus ();

  qsys_block_nios2e_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && bus.frame_valid && bus.frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=0x%0h/%0d required=none", bus.frame_buf, bus.frame_cnt);
      end else begin
        chk("frame", {bus.frame_buf, bus.frame_cnt}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [1:0] code);
    bus.dct_valid = 1'b1;
    bus.dct_code  = code;
    tick();
    bus.dct_valid = 1'b0;
    bus.dct_code  = 2'b00;
  endtask

  task automatic flush();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !bus.frame_valid) break;
      tick();
    end
    chk({name, "_pending"}, 34'(exp_q.size()), 34'd0);
    chk({name, "_valid"}, 34'(bus.frame_valid), 34'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.trc_on       = 1'b0;
    bus.dct_valid    = 1'b0;
    bus.dct_code     = 2'b00;
    bus.flush_req    = 1'b0;
    bus.frame_ready  = 1'b1;
    bus.overflow_clr = 1'b0;
    repeat (3) tick();
    chk("rst_frame_valid", 34'(bus.frame_valid), 34'd0);
    chk("rst_frame_cnt", 34'(bus.frame_cnt), 34'd0);
    chk("rst_frame_buf", 34'(bus.frame_buf), 34'd0);
    chk("rst_dct_count", 34'(bus.dct_count), 34'd0);
    chk("rst_dct_buffer", 34'(bus.dct_buffer), 34'd0);
    chk("rst_overflow", 34'(bus.overflow), 34'd0);
    reset_n = 1'b1;
    bus.trc_on = 1'b1;
    tick();

    // Full frame of taken codes.
    for (int i = 0; i < 14; i++) acc(2'b10);
    chk("full_cnt14", 34'(bus.dct_count), 34'd14);
    exp_q.push_back({30'h2AAAAAAA, 4'd15});
    acc(2'b10);
    chk("full_count_back0", 34'(bus.dct_count), 34'd0);
    chk("full_valid", 34'(bus.frame_valid), 34'd1);
    drain("full");

    // Early flush of three codes, then flush when empty.
    acc(2'b01); acc(2'b10); acc(2'b11);
    chk("flush_buffer", 34'(bus.dct_buffer), 34'h1B);
    exp_q.push_back({30'h1B, 4'd3});
    flush();
    chk("flush_count0", 34'(bus.dct_count), 34'd0);
    drain("flush");
    flush();
    chk("flush_empty_noframe", 34'(bus.frame_valid), 34'd0);

    // Accept coinciding with flush.
    acc(2'b01); acc(2'b01);
    exp_q.push_back({30'h16, 4'd3});
    bus.flush_req = 1'b1;
    acc(2'b10);
    bus.flush_req = 1'b0;
    drain("acc_flush");

    // Backpressure: first frame held, second dropped.
    bus.frame_ready = 1'b0;
    exp_q.push_back({30'h3, 4'd1});
    bus.flush_req = 1'b1;
    acc(2'b11);
    bus.flush_req = 1'b0;
    acc(2'b01);
    flush();
    chk("ovf_set", 34'(bus.overflow), 34'd1);
    chk("held_buf", 34'(bus.frame_buf), 34'h3);
    chk("held_cnt", 34'(bus.frame_cnt), 34'd1);
    chk("drop_live_clear", 34'(bus.dct_count), 34'd0);
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
    chk("drop_cnt1", 34'(bus.drop_cnt), 34'd1);
`endif
    tick();
    chk("held_buf_later", 34'(bus.frame_buf), 34'h3);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    chk("ovf_clr", 34'(bus.overflow), 34'd0);
`ifdef QSYS_BLOCK_NIOS2E_OCI_DCT_DROP_CNT_EN
    chk("drop_cnt_clr", 34'(bus.drop_cnt), 34'd0);
`endif
    bus.frame_ready = 1'b1;
    drain("held");

    // Ignored codes and trc_on falling edge.
    bus.trc_on = 1'b0;
    tick();
    acc(2'b10); acc(2'b01);
    chk("trc_off_ignored", 34'(bus.dct_count), 34'd0);
    chk("trc_off_noframe", 34'(bus.frame_valid), 34'd0);
    bus.trc_on = 1'b1;
    tick();
    acc(2'b10); acc(2'b10); acc(2'b10);
    acc(2'b00);
    chk("ill_ignored", 34'(bus.dct_count), 34'd3);
    acc(2'b01); acc(2'b01);
    chk("cnt5", 34'(bus.dct_count), 34'd5);
    exp_q.push_back({30'h2A5, 4'd5});
    bus.trc_on = 1'b0;
    tick();
    chk("trc_fall_count0", 34'(bus.dct_count), 34'd0);
    drain("trc_fall");
    bus.trc_on = 1'b1;
    tick();

    // Reset mid-frame with a pending frame.
    bus.frame_ready = 1'b0;
    bus.flush_req = 1'b1;
    acc(2'b01);
    bus.flush_req = 1'b0;
    for (int i = 0; i < 9; i++) acc(2'b10);
    chk("pre_rst_cnt9", 34'(bus.dct_count), 34'd9);
    chk("pre_rst_pending", 34'(bus.frame_valid), 34'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 34'(bus.frame_valid), 34'd0);
    chk("mid_rst_count", 34'(bus.dct_count), 34'd0);
    chk("mid_rst_buffer", 34'(bus.dct_buffer), 34'd0);
    chk("mid_rst_fbuf", 34'(bus.frame_buf), 34'd0);
    tick();
    reset_n = 1'b1;
    bus.frame_ready = 1'b1;
    tick();
    chk("post_rst_noframe", 34'(bus.frame_valid), 34'd0);
    acc(2'b10);
    chk("post_rst_count1", 34'(bus.dct_count), 34'd1);
    exp_q.push_back({30'h2, 4'd1});
    flush();
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
